// File: rtl/game_geom_pkg.sv
// Playfield geometry shared by the ball engine and the pixel renderer, plus the
// ball FSM state type and the idle serve-position helper.
package game_geom_pkg;

    localparam int H_DIS  = 800;
    localparam int V_DIS  = 600;
    localparam int SIDE   = 40;
    localparam int BLOCK  = 40;
    localparam int STICK  = 75;
    localparam int PAD_Y  = 462;
    localparam int PAD2_Y = 137;

    localparam logic [11:0] COL_BG   = 12'h000;
    localparam logic [11:0] COL_WALL = 12'hfff;
    localparam logic [11:0] COL_BALL = 12'hf80;
    localparam logic [11:0] COL_PAD  = 12'h0cf;

    // Ball travel limits in renderer coordinates (ball spans x+1..x+BLOCK)
    localparam int X_MIN = SIDE - 2;
    localparam int X_MAX = H_DIS - SIDE - BLOCK - 2;
    localparam int Y_TOP = PAD2_Y - 1;
    localparam int Y_BOT = PAD_Y - BLOCK;

    typedef enum logic [1:0] {IDLE, PLAY, MISS} ball_state_t;

    // Ball centred on the bottom paddle, kept inside the walls
    function automatic logic [9:0] serve_x(input logic [9:0] pad);
        logic [10:0] c;
        c = {1'b0, pad} + 11'((STICK - BLOCK) / 2);
        if (c > 11'(X_MAX))
            c = 11'(X_MAX);
        else if (c < 11'(X_MIN))
            c = 11'(X_MIN);
        return c[9:0];
    endfunction

endpackage

// File: rtl/paddle_overlap.sv
// Horizontal overlap between the ball and a paddle, compared in 11 bits so
// the right-edge sums cannot wrap.
module paddle_overlap
    import game_geom_pkg::*;
(
    input  logic [9:0] ball_x,
    input  logic [9:0] pad_x,
    output logic       overlap
);

    logic [10:0] bx, px;

    assign bx      = {1'b0, ball_x};
    assign px      = {1'b0, pad_x};
    assign overlap = (bx < px + 11'(STICK)) && (px < bx + 11'(BLOCK));

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics: tracks the bottom paddle while idle, moves and
// reflects the ball in play, and holds it for a fixed number of frames after a miss.
module ball_motion
    import game_geom_pkg::*;
#(
    parameter int STEP      = 4,
    parameter int MISS_WAIT = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] pad_x,
    input  logic [9:0] pad2_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       playing,
    output logic       hit,
    output logic       miss_bot,
    output logic       miss_top
);

    localparam int CW = $clog2(MISS_WAIT + 1);
    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YTOP_S = 11'(Y_TOP);
    localparam logic signed [10:0] YBOT_S = 11'(Y_BOT);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic [9:0]         X_HOME = 10'((H_DIS - BLOCK) / 2);

    ball_state_t state, state_nxt;
    logic [9:0]  x_nxt, y_nxt;
    logic        dx, dy, dx_nxt, dy_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        hit_nxt, mb_nxt, mt_nxt;
    logic        ov_bot, ov_top;
    logic signed [10:0] nx, ny;

    paddle_overlap u_ov_bot (.ball_x(ball_x), .pad_x(pad_x),  .overlap(ov_bot));
    paddle_overlap u_ov_top (.ball_x(ball_x), .pad_x(pad2_x), .overlap(ov_top));

    assign nx = $signed({1'b0, ball_x}) + (dx ? STEP_S : -STEP_S);
    assign ny = $signed({1'b0, ball_y}) + (dy ? STEP_S : -STEP_S);

    always_comb begin
        state_nxt = state;
        x_nxt     = ball_x;
        y_nxt     = ball_y;
        dx_nxt    = dx;
        dy_nxt    = dy;
        cnt_nxt   = cnt;
        hit_nxt   = 1'b0;
        mb_nxt    = 1'b0;
        mt_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    x_nxt = serve_x(pad_x);
                    y_nxt = 10'(Y_BOT);
                end
                if (serve) begin
                    state_nxt = PLAY;
                    dx_nxt    = 1'b1;
                    dy_nxt    = 1'b0;
                end
            end
            PLAY: if (frame_tick) begin
                if (nx >= XMAX_S) begin
                    x_nxt  = 10'(X_MAX);
                    dx_nxt = 1'b0;
                end else if (nx <= XMIN_S) begin
                    x_nxt  = 10'(X_MIN);
                    dx_nxt = 1'b1;
                end else begin
                    x_nxt  = nx[9:0];
                end
                // Paddle test uses the pre-move x so a corner graze counts as it looked
                if (dy && ny >= YBOT_S) begin
                    y_nxt = 10'(Y_BOT);
                    if (ov_bot) begin
                        dy_nxt  = 1'b0;
                        hit_nxt = 1'b1;
                    end else begin
                        mb_nxt    = 1'b1;
                        state_nxt = MISS;
                        cnt_nxt   = CW'(MISS_WAIT);
                    end
                end else if (!dy && ny <= YTOP_S) begin
                    y_nxt = 10'(Y_TOP);
                    if (ov_top) begin
                        dy_nxt  = 1'b1;
                        hit_nxt = 1'b1;
                    end else begin
                        mt_nxt    = 1'b1;
                        state_nxt = MISS;
                        cnt_nxt   = CW'(MISS_WAIT);
                    end
                end else begin
                    y_nxt = ny[9:0];
                end
            end
            MISS: if (frame_tick) begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ball_x   <= X_HOME;
            ball_y   <= 10'(Y_BOT);
            dx       <= 1'b1;
            dy       <= 1'b0;
            cnt      <= '0;
            playing  <= 1'b0;
            hit      <= 1'b0;
            miss_bot <= 1'b0;
            miss_top <= 1'b0;
        end else begin
            state    <= state_nxt;
            ball_x   <= x_nxt;
            ball_y   <= y_nxt;
            dx       <= dx_nxt;
            dy       <= dy_nxt;
            cnt      <= cnt_nxt;
            playing  <= (state_nxt == PLAY);
            hit      <= hit_nxt;
            miss_bot <= mb_nxt;
            miss_top <= mt_nxt;
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Randomised bench for ball_motion against a plain-integer model of the game rules.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, frame_tick = 1'b0, serve = 1'b0;
    logic [9:0] pad_x = '0, pad2_x = '0;
    logic [9:0] ball_x, ball_y;
    logic       playing, hit, miss_bot, miss_top;
    logic [23:0] dut_vec;

    ball_motion dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve),
        .pad_x(pad_x), .pad2_x(pad2_x), .ball_x(ball_x), .ball_y(ball_y),
        .playing(playing), .hit(hit), .miss_bot(miss_bot), .miss_top(miss_top)
    );

    always #5 clk = ~clk;

    assign dut_vec = {ball_x, ball_y, playing, hit, miss_bot, miss_top};

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 play, 2 miss
    localparam int MI = 0, MP = 1, MM = 2;
    int m_st = MI, m_x = 380, m_y = 422, m_cnt = 0;
    bit m_dx = 1, m_dy = 0, m_hit = 0, m_mb = 0, m_mt = 0;

    function automatic bit ovl(int bx, int px);
        return (bx < px + 75) && (px < bx + 40);
    endfunction

    function automatic int clampi(int v);
        return (v > 718) ? 718 : (v < 38) ? 38 : v;
    endfunction

    function automatic logic [23:0] exp_vec();
        return {10'(m_x), 10'(m_y), (m_st == MP), m_hit, m_mb, m_mt};
    endfunction

    task automatic model_step();
        int nx, ny, ox;
        m_hit = 0; m_mb = 0; m_mt = 0;
        if (!rst_n) begin
            m_st = MI; m_x = 380; m_y = 422; m_dx = 1; m_dy = 0; m_cnt = 0;
            return;
        end
        if (m_st == MI) begin
            if (frame_tick) begin
                m_x = clampi(int'(pad_x) + 17);
                m_y = 422;
            end
            if (serve) begin m_st = MP; m_dx = 1; m_dy = 0; end
        end else if (m_st == MP) begin
            if (frame_tick) begin
                ox = m_x;
                nx = m_dx ? m_x + 4 : m_x - 4;
                ny = m_dy ? m_y + 4 : m_y - 4;
                if (nx >= 718)     begin m_x = 718; m_dx = 0; end
                else if (nx <= 38) begin m_x = 38;  m_dx = 1; end
                else m_x = nx;
                if (m_dy && ny >= 422) begin
                    m_y = 422;
                    if (ovl(ox, int'(pad_x))) begin m_dy = 0; m_hit = 1; end
                    else begin m_mb = 1; m_st = MM; m_cnt = 60; end
                end else if (!m_dy && ny <= 136) begin
                    m_y = 136;
                    if (ovl(ox, int'(pad2_x))) begin m_dy = 1; m_hit = 1; end
                    else begin m_mt = 1; m_st = MM; m_cnt = 60; end
                end else begin
                    m_y = ny;
                end
            end
        end else begin
            if (frame_tick) begin
                if (m_cnt == 0) m_st = MI;
                else m_cnt--;
            end
        end
    endtask

    // Drive one clock with the given controls; model advances on the same edge
    task automatic cycle(input bit r, input bit t, input bit s);
        rst_n = r; frame_tick = t; serve = s;
        @(posedge clk);
        model_step();
        #1;
        frame_tick = 1'b0;
    endtask

    function automatic logic [9:0] pad_hit(int bx);
        int lo;
        lo = (bx > 74) ? bx - 74 : 0;
        case ($urandom_range(3, 0))
            0:       return 10'(lo);
            1:       return 10'(bx + 39);
            default: return 10'(int'($urandom_range(32'(bx + 39), 32'(lo))));
        endcase
    endfunction

    function automatic logic [9:0] pad_miss(int bx);
        case ($urandom_range(3, 0))
            0:       return 10'(bx + 40);
            1:       return (bx >= 75) ? 10'(bx - 75) : 10'(bx + 40);
            2:       return 10'(int'($urandom_range(1023, 32'(bx + 40))));
            default: return (bx >= 75) ? 10'(int'($urandom_range(32'(bx - 75), 0))) : 10'(bx + 40);
        endcase
    endfunction

    task automatic test_reset();
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        total++;
        if (dut_vec !== {10'd380, 10'd422, 4'b0000}) begin
            bad++; $display("FAIL reset_values: got %h want %h", dut_vec, {10'd380, 10'd422, 4'b0000});
        end
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_idle_track();
        cycle(1, 0, 0);
        pad_x = 10'd300;
        cycle(1, 1, 0);
        total++;
        if (ball_x !== 10'd317 || ball_y !== 10'd422 || playing !== 1'b0) begin
            bad++; $display("FAIL idle_track_300: got x=%0d y=%0d p=%b want x=317 y=422 p=0", ball_x, ball_y, playing);
        end
        pad_x = 10'd0;
        cycle(1, 0, 0);
        total++;
        if (ball_x !== 10'd317) begin
            bad++; $display("FAIL idle_no_tick: got x=%0d want x=317", ball_x);
        end
        cycle(1, 1, 0);
        total++;
        if (ball_x !== 10'd38) begin
            bad++; $display("FAIL idle_clamp_lo: got x=%0d want x=38", ball_x);
        end
        pad_x = 10'd1000;
        cycle(1, 1, 0);
        total++;
        if (ball_x !== 10'd718) begin
            bad++; $display("FAIL idle_clamp_hi: got x=%0d want x=718", ball_x);
        end
        for (int i = 0; i < 20; i++) begin
            pad_x = 10'($urandom_range(1023, 0));
            cycle(1, 1, 0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL idle_rand: got %h want %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_serve();
        pad_x = 10'd300;
        cycle(1, 1, 1);
        total++;
        if (dut_vec !== {10'd317, 10'd422, 4'b1000}) begin
            bad++; $display("FAIL serve_with_tick: got %h want %h", dut_vec, {10'd317, 10'd422, 4'b1000});
        end
        for (int f = 0; f < 3; f++) begin
            cycle(1, 1, 0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL serve_move: got %h want %h", dut_vec, exp_vec());
            end
            cycle(1, 0, 0);
        end
        total++;
        if (dut_vec !== {10'd329, 10'd410, 4'b1000}) begin
            bad++; $display("FAIL serve_3ticks: got %h want %h", dut_vec, {10'd329, 10'd410, 4'b1000});
        end
    endtask

    task automatic test_play_random();
        for (int f = 0; f < 900; f++) begin
            pad_x  = ($urandom_range(31, 0) == 0) ? pad_miss(m_x) : pad_hit(m_x);
            pad2_x = ($urandom_range(31, 0) == 0) ? pad_miss(m_x) : pad_hit(m_x);
            if ($urandom_range(499, 0) == 0) cycle(0, 0, 0);
            cycle(1, 1, $urandom_range(7, 0) == 0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL play_tick f=%0d: got %h want %h", f, dut_vec, exp_vec());
            end
            for (int g = int'($urandom_range(3, 0)); g > 0; g--) begin
                pad_x  = 10'($urandom_range(1023, 0));
                pad2_x = 10'($urandom_range(1023, 0));
                cycle(1, 0, $urandom_range(7, 0) == 0);
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL play_gap f=%0d: got %h want %h", f, dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_miss();
        int fx, fy;
        bit seen;
        for (int s = 0; s < 2; s++) begin
            cycle(0, 0, 0);
            pad_x = 10'd300;
            cycle(1, 1, 1);
            seen = 0;
            for (int f = 0; f < 250 && !seen; f++) begin
                pad_x  = (s == 0) ? pad_hit(m_x)  : pad_miss(m_x);
                pad2_x = (s == 0) ? pad_miss(m_x) : pad_hit(m_x);
                cycle(1, 1, 0);
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL miss_approach s=%0d: got %h want %h", s, dut_vec, exp_vec());
                end
                seen = (s == 0) ? (miss_top === 1'b1) : (miss_bot === 1'b1);
                cycle(1, 0, 0);
            end
            total++;
            if (!seen || ball_y !== ((s == 0) ? 10'd136 : 10'd422)) begin
                bad++; $display("FAIL miss_detect s=%0d: got seen=%0b y=%0d want seen=1 y=%0d", s, seen, ball_y, (s == 0) ? 136 : 422);
            end
            fx = int'(ball_x); fy = int'(ball_y);
            for (int f = 0; f < 61; f++) begin
                pad_x  = 10'($urandom_range(1023, 0));
                pad2_x = 10'($urandom_range(1023, 0));
                cycle(1, 1, f < 30);
                total++;
                if (dut_vec !== {10'(fx), 10'(fy), 4'b0000} || dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL miss_frozen s=%0d f=%0d: got %h want %h", s, f, dut_vec, {10'(fx), 10'(fy), 4'b0000});
                end
            end
            pad_x = 10'd500;
            cycle(1, 1, 0);
            total++;
            if (dut_vec !== {10'd517, 10'd422, 4'b0000}) begin
                bad++; $display("FAIL miss_to_idle s=%0d: got %h want %h", s, dut_vec, {10'd517, 10'd422, 4'b0000});
            end
        end
    endtask

    task automatic test_midplay_reset();
        pad_x = 10'd300;
        cycle(1, 1, 1);
        for (int f = 0; f < 10; f++) cycle(1, 1, 0);
        cycle(0, 0, 0);
        total++;
        if (dut_vec !== {10'd380, 10'd422, 4'b0000}) begin
            bad++; $display("FAIL midplay_reset: got %h want %h", dut_vec, {10'd380, 10'd422, 4'b0000});
        end
        pad_x = 10'd100;
        cycle(1, 1, 1);
        cycle(1, 1, 0);
        total++;
        if (dut_vec !== {10'd121, 10'd418, 4'b1000} || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_dirs: got %h want %h", dut_vec, {10'd121, 10'd418, 4'b1000});
        end
    endtask

    initial begin
        test_reset();
        test_idle_track();
        test_serve();
        test_play_random();
        test_miss();
        test_midplay_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
